riscv_hwloop_jump_ctrl: RTL



---
 rtl/riscv_hwloop_jump_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/riscv_hwloop_jump_ctrl.sv
// rtl/riscv_hwloop_jump_ctrl.sv - hardware-loop end match, counter decrement strobes and fetch jump request
// Optional taken-jump counter enabled by RISCV_HWLP_PERF_CNT_EN.
module riscv_hwloop_jump_ctrl #(
   parameter int N_REGS     = 2,
   parameter int N_REG_BITS = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [31:0]       current_pc_i,
   input  logic              instr_retire_i,
   input  logic [31:0]       hwlp_start_addr_i [N_REGS],
   input  logic [31:0]       hwlp_end_addr_i   [N_REGS],
   input  logic [31:0]       hwlp_counter_i    [N_REGS],
   input  logic              flush_i,
   input  logic              fetch_ready_i,
   output logic [N_REGS-1:0] hwlp_dec_cnt_o,
   output logic              hwlp_jump_o,
   output logic [31:0]       hwlp_targ_addr_o,
   output logic              hwlp_busy_o,
   output logic [31:0]       perf_hwlp_jumps_o
);

   typedef enum logic {
      IDLE    = 1'b0,
      PENDING = 1'b1
   } state_e;

   state_e                state_q;
   state_e                state_d;
   logic [N_REGS-1:0]     match;
   logic [N_REGS-1:0]     taken;
   logic [N_REG_BITS-1:0] sel;
   logic                  taken_any;
   logic                  hit;
   logic [31:0]           targ_q;

   // A zero counter marks a disabled loop; a counter of one is the final pass (exit, no jump).
   always_comb begin
      match = '0;
      taken = '0;
      for (int k = 0; k < N_REGS; k++) begin
         match[k] = (hwlp_end_addr_i[k] == current_pc_i) && (hwlp_counter_i[k] != 32'd0);
         taken[k] = match[k] && (hwlp_counter_i[k] > 32'd1);
      end
   end

   always_comb begin
      sel = '0;
      for (int k = N_REGS - 1; k >= 0; k--) begin
         if (taken[k]) sel = N_REG_BITS'(k);
      end
   end

   assign taken_any = |taken;
   assign hit       = instr_retire_i && (state_q == IDLE) && !flush_i && (|match);

   // Inner loops that end here finish their iteration as well when an outer loop jumps.
   always_comb begin
      hwlp_dec_cnt_o = '0;
      if (hit) begin
         for (int k = 0; k < N_REGS; k++) begin
            hwlp_dec_cnt_o[k] = match[k] && (!taken_any || (k <= int'(sel)));
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (hit && taken_any) state_d = PENDING;
         PENDING: if (flush_i || fetch_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         targ_q  <= '0;
      end else begin
         state_q <= state_d;
         if ((state_q == IDLE) && (state_d == PENDING)) targ_q <= hwlp_start_addr_i[sel];
      end
   end

   assign hwlp_jump_o      = (state_q == PENDING);
   assign hwlp_busy_o      = (state_q == PENDING);
   assign hwlp_targ_addr_o = targ_q;

`ifdef RISCV_HWLP_PERF_CNT_EN
   logic        jump_done;
   logic [31:0] perf_cnt_q;

   assign jump_done = (state_q == PENDING) && fetch_ready_i && !flush_i;

   always_ff @(posedge clk) begin
      if (rst)            perf_cnt_q <= '0;
      else if (jump_done) perf_cnt_q <= perf_cnt_q + 32'd1;
   end

   assign perf_hwlp_jumps_o = perf_cnt_q;
`else
   assign perf_hwlp_jumps_o = '0;
`endif

endmodule
